// File: rtl/exec_unit.sv
// Execute/write-back stage in front of a 4x8 register file: ALU, shift and shift-add multiply.
// Latency 3 cycles (MUL 10); instr_ready is low while busy and the source holds instr until accepted.
module exec_unit (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      instr,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [3:0][7:0] regs_rd,
   output logic [3:0][7:0] regs_in,
   output logic [3:0]      write_en,
   output logic            flag_z,
   output logic            flag_c,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   typedef struct packed {
      logic [2:0] op;
      logic       dir;
      logic [1:0] dst;
      logic [1:0] src;
   } instr_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_SHF = 3'd7;

   state_t      state, state_n;
   instr_t      ir;
   logic [2:0]  cnt;
   logic [15:0] acc;
   logic [15:0] mcand;
   logic [7:0]  mplier;
   logic [7:0]  result;

   logic        first;
   logic        exec_done;
   logic [7:0]  op_a, op_b;
   logic [15:0] mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_acc;
   logic [7:0]  alu_r;
   logic        alu_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Operands are live from the register file only in the first EXEC cycle;
   // later MUL iterations run on the latched multiplicand/multiplier.
   always_comb begin
      first     = (cnt == 3'd0);
      op_a      = regs_rd[ir.dst];
      op_b      = regs_rd[ir.src];
      mul_a     = first ? {8'h00, op_a} : mcand;
      mul_b     = first ? op_b : mplier;
      mul_acc   = (first ? 16'h0000 : acc) + (mul_b[0] ? mul_a : 16'h0000);
      exec_done = (ir.op != OP_MUL) || (cnt == 3'd7);

      alu_r = 8'h00;
      alu_c = 1'b0;
      case (ir.op)
         OP_ADD: {alu_c, alu_r} = {1'b0, op_a} + {1'b0, op_b};
         OP_SUB: begin
            alu_r = op_a - op_b;
            alu_c = (op_a < op_b);
         end
         OP_AND: alu_r = op_a & op_b;
         OP_OR:  alu_r = op_a | op_b;
         OP_XOR: alu_r = op_a ^ op_b;
         OP_MOV: alu_r = op_b;
         OP_MUL: begin
            alu_r = mul_acc[7:0];
            alu_c = |mul_acc[15:8];
         end
         OP_SHF: begin
            if (ir.dir) begin
               alu_r = {1'b0, op_a[7:1]};
               alu_c = op_a[0];
            end else begin
               alu_r = {op_a[6:0], 1'b0};
               alu_c = op_a[7];
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n     = state;
      instr_ready = 1'b0;
      busy        = 1'b0;
      write_en    = 4'b0000;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_n = EXEC;
         end
         EXEC: begin
            busy = 1'b1;
            if (exec_done) state_n = WB;
         end
         WB: begin
            busy     = 1'b1;
            write_en = 4'b0001 << ir.dst;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      regs_in = {4{result}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir     <= '0;
         cnt    <= 3'd0;
         acc    <= 16'h0000;
         mcand  <= 16'h0000;
         mplier <= 8'h00;
         result <= 8'h00;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else begin
         if (state == IDLE && instr_valid) begin
            ir  <= instr_t'(instr);
            cnt <= 3'd0;
         end
         if (state == EXEC) begin
            if (ir.op == OP_MUL) begin
               acc    <= mul_acc;
               mcand  <= mul_a << 1;
               mplier <= mul_b >> 1;
               cnt    <= cnt + 3'd1;
            end
            if (exec_done) begin
               result <= alu_r;
               flag_z <= (alu_r == 8'h00);
               flag_c <= alu_c;
               cnt    <= 3'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: behavioural register file, scoreboard of expected write-backs, directed steps.
module tb_exec_unit;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7:0]      instr;
   logic            instr_valid;
   logic            instr_ready;
   logic [3:0][7:0] rf;
   logic [3:0][7:0] rf_init;
   logic [3:0][7:0] rf_snap;
   logic            rf_load;
   logic [3:0][7:0] regs_in;
   logic [3:0]      write_en;
   logic            flag_z, flag_c, busy;

   int n_chk  = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int hs_cnt = 0;
   int hs0, wr0;

   typedef struct packed {
      logic [3:0] we;
      logic [7:0] r;
      logic       z;
      logic       c;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   exec_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .regs_rd     (rf),
      .regs_in     (regs_in),
      .write_en    (write_en),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .busy        (busy)
   );

   // Register file model plus write/handshake counters
   always @(posedge clk) begin
      if (rf_load) rf <= rf_init;
      else
         for (int i = 0; i < 4; i++)
            if (write_en[i]) rf[i] <= regs_in[i];
      if (|write_en) wr_cnt <= wr_cnt + 1;
      if (rst_n && instr_valid && instr_ready) hs_cnt <= hs_cnt + 1;
   end

   function automatic exp_t model(input logic [7:0] ins, input logic [3:0][7:0] rv);
      exp_t        e;
      logic [7:0]  a, b;
      logic [8:0]  s9;
      logic [15:0] p;
      a = rv[ins[3:2]];
      b = rv[ins[1:0]];
      e.c = 1'b0;
      e.r = 8'h00;
      case (ins[7:5])
         3'd0: begin s9 = {1'b0, a} + {1'b0, b}; e.r = s9[7:0]; e.c = s9[8]; end
         3'd1: begin e.r = a - b; e.c = (a < b); end
         3'd2: e.r = a & b;
         3'd3: e.r = a | b;
         3'd4: e.r = a ^ b;
         3'd5: e.r = b;
         3'd6: begin p = 16'(a) * 16'(b); e.r = p[7:0]; e.c = |p[15:8]; end
         default: begin
            if (ins[4]) begin e.r = a >> 1; e.c = a[0]; end
            else        begin e.r = a << 1; e.c = a[7]; end
         end
      endcase
      e.z  = (e.r == 8'h00);
      e.we = 4'b0001 << ins[3:2];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] ins);
      int n;
      n = 0;
      instr = ins;
      instr_valid = 1'b1;
      while (!instr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept", {31'd0, instr_ready}, 32'd1);
      sb.push_back(model(ins, rf));
      @(negedge clk);
   endtask

   task automatic wait_wb(input string tag, input int lat);
      int   n;
      exp_t e;
      n = 1;
      chk({tag, "_rdy_exec"}, {31'd0, instr_ready}, 32'd0);
      while (write_en == 4'b0000 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, lat);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk({tag, "_we"},   {28'd0, write_en}, {28'd0, e.we});
      chk({tag, "_data"}, regs_in, {4{e.r}});
      chk({tag, "_z"},    {31'd0, flag_z}, {31'd0, e.z});
      chk({tag, "_c"},    {31'd0, flag_c}, {31'd0, e.c});
      chk({tag, "_rdy_wb"}, {31'd0, instr_ready}, 32'd0);
      chk({tag, "_busy_wb"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({tag, "_rdy_after"}, {31'd0, instr_ready}, 32'd1);
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({tag, "_we_after"}, {28'd0, write_en}, 32'd0);
      chk({tag, "_hold"}, regs_in, {4{e.r}});
   endtask

   task automatic poke(input int idx, input logic [7:0] v);
      rf_init = rf;
      rf_init[idx] = v;
      rf_load = 1'b1;
      @(negedge clk);
      rf_load = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      instr       = 8'h00;
      instr_valid = 1'b0;
      rf_init     = {8'd16, 8'd8, 8'd4, 8'd2};
      rf_load     = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rdy",  {31'd0, instr_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_we",   {28'd0, write_en}, 32'd0);
      chk("rst_data", regs_in, 32'd0);
      chk("rst_z",    {31'd0, flag_z}, 32'd0);
      chk("rst_c",    {31'd0, flag_c}, 32'd0);
      rf_load = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);

      send(8'h01); instr_valid = 1'b0; wait_wb("add", 2);
      chk("add_r0", {24'd0, rf[0]}, 32'd6);
      send(8'h20); instr_valid = 1'b0; wait_wb("sub_self", 2);
      send(8'h24); instr_valid = 1'b0; wait_wb("sub_r1", 2);
      chk("sub_r1_val", {24'd0, rf[1]}, 32'd4);
      send(8'hCE); instr_valid = 1'b0; wait_wb("mul_16x8", 9);
      chk("mul_r3", {24'd0, rf[3]}, 32'd128);
      send(8'hCF); instr_valid = 1'b0; wait_wb("mul_ovf", 9);
      send(8'h62); instr_valid = 1'b0; wait_wb("or", 2);
      send(8'h87); instr_valid = 1'b0; wait_wb("xor", 2);
      send(8'hA3); instr_valid = 1'b0; wait_wb("mov", 2);

      // AND held valid across a whole MUL
      hs0 = hs_cnt;
      wr0 = wr_cnt;
      send(8'hC9);
      instr = 8'h41;
      instr_valid = 1'b1;
      wait_wb("bp_mul", 9);
      chk("bp_not_taken", hs_cnt - hs0, 1);
      send(8'h41); instr_valid = 1'b0; wait_wb("bp_and", 2);
      chk("bp_accept_once", hs_cnt - hs0, 2);
      chk("bp_writes", wr_cnt - wr0, 2);

      poke(0, 8'h02);
      send(8'hF0); instr_valid = 1'b0; wait_wb("shr", 2);
      poke(0, 8'h81);
      send(8'hE0); instr_valid = 1'b0; wait_wb("shl", 2);

      // Reset four cycles into a MUL
      send(8'hCE);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      rf_snap = rf;
      wr0     = wr_cnt;
      rst_n   = 1'b0;
      #1;
      chk("abort_we",   {28'd0, write_en}, 32'd0);
      chk("abort_z",    {31'd0, flag_z}, 32'd0);
      chk("abort_c",    {31'd0, flag_c}, 32'd0);
      chk("abort_rdy",  {31'd0, instr_ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      void'(sb.pop_back());
      instr       = 8'h01;
      instr_valid = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hs0   = hs_cnt;
      send(8'h01);
      instr_valid = 1'b0;
      chk("release_accept", hs_cnt - hs0, 1);
      chk("abort_no_write", wr_cnt - wr0, 0);
      chk("abort_rf", rf, rf_snap);
      wait_wb("post_rst", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
